pattern_sequencer: RTL and testbench

Fetches note entries from a per-channel pattern memory on request and hands the decoded pitch index and duration downstream. It is the stage directly upstream of the channel controller. The controller pulses `i_enable`, and this block answers with a one-cycle `o_valid` once the next playable entry is decoded. Jump and end-of-pattern entries are resolved internally, so the controller only ever sees notes, rests or end markers.

---
 rtl/pattern_sequencer_if.sv | 32 +++
 rtl/pattern_sequencer.sv | 153 +++++++++++++++
 tb/tb_pattern_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_sequencer_if.sv
// Purpose: bundles the request/response strobes and pattern-memory read port of pattern_sequencer.
// Ports: i_enable/i_restart (controller requests), o_* (decoded entry + status), o_mem_addr/i_mem_data (memory).
// slave modport = sequencer side, master modport = controller + memory side.
interface pattern_sequencer_if #(
  parameter int ADDR_WIDTH     = 8,
  parameter int NOTE_WIDTH     = 6,
  parameter int DURATION_WIDTH = 8
) ();
  localparam int DATA_WIDTH = 2 + NOTE_WIDTH + DURATION_WIDTH;

  logic                      i_enable;
  logic                      i_restart;
  logic                      o_valid;
  logic [NOTE_WIDTH-1:0]     o_note;
  logic [DURATION_WIDTH-1:0] o_duration;
  logic                      o_rest;
  logic                      o_end;
  logic                      o_error;
  logic                      o_busy;
  logic [ADDR_WIDTH-1:0]     o_mem_addr;
  logic [DATA_WIDTH-1:0]     i_mem_data;

  modport slave (
    input  i_enable, i_restart, i_mem_data,
    output o_valid, o_note, o_duration, o_rest, o_end, o_error, o_busy, o_mem_addr
  );

  modport master (
    output i_enable, i_restart, i_mem_data,
    input  o_valid, o_note, o_duration, o_rest, o_end, o_error, o_busy, o_mem_addr
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Purpose: fetch the next playable pattern entry on request, resolving JUMPs internally.
// Latency: o_valid 3 cycles after i_enable, plus 2 cycles per followed jump.
// Backpressure: none; i_enable while o_busy is dropped, not queued. i_restart wins over i_enable.
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport of pattern_sequencer_if).
module pattern_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int NOTE_WIDTH     = 6,
  parameter int DURATION_WIDTH = 8,
  parameter int MAX_JUMPS      = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pattern_sequencer_if.slave  bus
);
  localparam int DATA_WIDTH = 2 + NOTE_WIDTH + DURATION_WIDTH;
  localparam int JCNT_W     = $clog2(MAX_JUMPS + 1);
  localparam logic [JCNT_W-1:0] JMAX = JCNT_W'(MAX_JUMPS);

  localparam logic [1:0] OP_NOTE = 2'b00;
  localparam logic [1:0] OP_REST = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DECODE} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic [JCNT_W-1:0]         jcnt_q, jcnt_d;
  logic                      valid_q, valid_d;
  logic [NOTE_WIDTH-1:0]     note_q, note_d;
  logic [DURATION_WIDTH-1:0] dur_q, dur_d;
  logic                      rest_q, rest_d;
  logic                      end_q, end_d;
  logic                      error_q, error_d;

  logic [1:0]                op;
  logic [NOTE_WIDTH-1:0]     f_note;
  logic [DURATION_WIDTH-1:0] f_dur;
  logic [ADDR_WIDTH-1:0]     f_target;
  logic                      jump_ok;

  assign op       = bus.i_mem_data[DATA_WIDTH-1 -: 2];
  assign f_note   = bus.i_mem_data[DURATION_WIDTH +: NOTE_WIDTH];
  assign f_dur    = bus.i_mem_data[DURATION_WIDTH-1:0];
  assign f_target = bus.i_mem_data[ADDR_WIDTH-1:0];
  assign jump_ok  = (jcnt_q < JMAX);

  // State register plus all datapath flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      jcnt_q  <= '0;
      valid_q <= 1'b0;
      note_q  <= '0;
      dur_q   <= '0;
      rest_q  <= 1'b1;
      end_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      jcnt_q  <= jcnt_d;
      valid_q <= valid_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      rest_q  <= rest_d;
      end_q   <= end_d;
      error_q <= error_d;
    end
  end

  // Next state and next datapath values.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    jcnt_d  = jcnt_q;
    valid_d = 1'b0;
    note_d  = note_q;
    dur_d   = dur_q;
    rest_d  = rest_q;
    end_d   = end_q;
    error_d = error_q;

    if (bus.i_restart) begin
      // Drops any in-flight request: valid_d stays 0.
      state_d = S_IDLE;
      pc_d    = '0;
      end_d   = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_enable) begin
            state_d = S_READ;
            jcnt_d  = '0;
          end
        end
        S_READ: state_d = S_DECODE;
        S_DECODE: begin
          state_d = S_IDLE;
          case (op)
            OP_NOTE, OP_REST: begin
              valid_d = 1'b1;
              rest_d  = (op == OP_REST);
              note_d  = (op == OP_REST) ? '0 : f_note;
              dur_d   = f_dur;
              end_d   = 1'b0;
              pc_d    = pc_q + ADDR_WIDTH'(1);
            end
            OP_JUMP: begin
              pc_d = f_target;
              if (jump_ok) begin
                jcnt_d  = jcnt_q + JCNT_W'(1);
                state_d = S_READ;
              end else begin
                // Jump budget exhausted: return a silent entry and flag it.
                valid_d = 1'b1;
                rest_d  = 1'b1;
                note_d  = '0;
                dur_d   = '0;
                end_d   = 1'b0;
                error_d = 1'b1;
              end
            end
            OP_END: begin
              // pc left on the END entry so later requests hit it again.
              valid_d = 1'b1;
              rest_d  = 1'b1;
              end_d   = 1'b1;
              note_d  = '0;
              dur_d   = '0;
            end
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.o_busy     = (state_q != S_IDLE);
    bus.o_valid    = valid_q;
    bus.o_note     = note_q;
    bus.o_duration = dur_q;
    bus.o_rest     = rest_q;
    bus.o_end      = end_q;
    bus.o_error    = error_q;
    bus.o_mem_addr = pc_q;
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_sequencer_if #(.ADDR_WIDTH(8), .NOTE_WIDTH(6), .DURATION_WIDTH(8)) ifc ();
  pattern_sequencer #(.ADDR_WIDTH(8), .NOTE_WIDTH(6), .DURATION_WIDTH(8), .MAX_JUMPS(4)) dut (
    .i_clk(clk), .i_rst(rst), .bus(ifc)
  );

  logic [15:0] mem [0:255];
  always_ff @(posedge clk) ifc.i_mem_data <= mem[ifc.o_mem_addr];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] w_note(input int n, input int d);
    w_note = {2'b00, 6'(n), 8'(d)};
  endfunction
  function automatic logic [15:0] w_rest(input int n, input int d);
    w_rest = {2'b01, 6'(n), 8'(d)};
  endfunction
  function automatic logic [15:0] w_jump(input int t);
    w_jump = {2'b10, 6'd0, 8'(t)};
  endfunction
  function automatic logic [15:0] w_end();
    w_end = {2'b11, 14'd0};
  endfunction

  // Called #1 after a posedge; returns #1 after the posedge of the o_valid cycle (lat=-1 on timeout).
  task automatic request(input int budget, output int lat, output logic busy1);
    ifc.i_enable = 1'b1;
    lat = -1;
    busy1 = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      ifc.i_enable = 1'b0;
      if (k == 1) busy1 = ifc.o_busy;
      if (ifc.o_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_restart();
    ifc.i_restart = 1'b1;
    step();
    ifc.i_restart = 1'b0;
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (ifc.o_valid) cnt++;
    end
  endtask

  task automatic chk_entry(input string tag, input int note, input int dur, input int rest, input int en);
    chk({tag, "_note"}, 32'(ifc.o_note), 32'(note));
    chk({tag, "_dur"},  32'(ifc.o_duration), 32'(dur));
    chk({tag, "_rest"}, 32'(ifc.o_rest), 32'(rest));
    chk({tag, "_end"},  32'(ifc.o_end), 32'(en));
  endtask

  typedef struct {
    logic [15:0] word;
    int          note;
    int          dur;
    int          rest;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   lat;
    int   cnt;
    logic busy1;

    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    ifc.i_enable  = 1'b0;
    ifc.i_restart = 1'b0;

    vecs[0] = '{w_note(12, 5),   12, 5,   0};
    vecs[1] = '{w_rest(9, 3),    0,  3,   1};
    vecs[2] = '{w_note(63, 255), 63, 255, 0};
    vecs[3] = '{w_note(7, 0),    7,  0,   0};
    vecs[4] = '{w_rest(0, 0),    0,  0,   1};
    for (int i = 0; i < 5; i++) mem[i] = vecs[i].word;
    mem[5] = w_end();

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(ifc.o_valid), 0);
    chk("rst_busy", 32'(ifc.o_busy), 0);
    chk("rst_error", 32'(ifc.o_error), 0);
    chk("rst_addr", 32'(ifc.o_mem_addr), 0);
    chk_entry("rst", 0, 0, 1, 0);

    // Table of plain NOTE/REST entries fetched back to back
    for (int i = 0; i < 5; i++) begin
      request(10, lat, busy1);
      chk($sformatf("v%0d_lat", i), 32'(lat), 3);
      chk($sformatf("v%0d_busy1", i), 32'(busy1), 1);
      chk($sformatf("v%0d_busyv", i), 32'(ifc.o_busy), 0);
      chk_entry($sformatf("v%0d", i), vecs[i].note, vecs[i].dur, vecs[i].rest, 0);
      chk($sformatf("v%0d_addr", i), 32'(ifc.o_mem_addr), 32'(i + 1));
      step();
      chk($sformatf("v%0d_pulse", i), 32'(ifc.o_valid), 0);
    end

    // END repeats and pc sticks
    for (int r = 0; r < 3; r++) begin
      request(10, lat, busy1);
      chk($sformatf("end%0d_lat", r), 32'(lat), 3);
      chk_entry($sformatf("end%0d", r), 0, 0, 1, 1);
      chk($sformatf("end%0d_addr", r), 32'(ifc.o_mem_addr), 5);
    end
    pulse_restart();
    chk("rs_addr", 32'(ifc.o_mem_addr), 0);
    chk("rs_end", 32'(ifc.o_end), 0);
    request(10, lat, busy1);
    chk("rs_lat", 32'(lat), 3);
    chk_entry("rs", 12, 5, 0, 0);

    // Single jump adds two cycles
    pulse_restart();
    mem[0] = w_jump(8'h20);
    mem[8'h20] = w_rest(4, 3);
    request(20, lat, busy1);
    chk("j1_lat", 32'(lat), 5);
    chk_entry("j1", 0, 3, 1, 0);
    chk("j1_addr", 32'(ifc.o_mem_addr), 32'h21);
    chk("j1_error", 32'(ifc.o_error), 0);

    // Self-loop exhausts jump budget
    pulse_restart();
    mem[0] = w_jump(0);
    request(30, lat, busy1);
    chk("loop_lat", 32'(lat), 11);
    chk("loop_error", 32'(ifc.o_error), 1);
    chk_entry("loop", 0, 0, 1, 0);
    chk("loop_addr", 32'(ifc.o_mem_addr), 0);
    repeat (5) step();
    chk("loop_sticky", 32'(ifc.o_error), 1);
    pulse_restart();
    chk("loop_clear", 32'(ifc.o_error), 0);

    // Address wrap at 0xFF; extra enables while busy are ignored
    mem[0] = w_jump(8'hFF);
    mem[8'hFF] = w_note(1, 1);
    ifc.i_enable = 1'b1;
    cnt = 0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) ifc.i_enable = 1'b0;
      if (ifc.o_valid) begin
        cnt++;
        if (lat < 0) begin
          lat = k;
          chk_entry("wrap", 1, 1, 0, 0);
          chk("wrap_addr", 32'(ifc.o_mem_addr), 0);
        end
      end
    end
    chk("wrap_lat", 32'(lat), 5);
    chk("wrap_nvalid", 32'(cnt), 1);

    // Restart in the DECODE cycle drops the request
    pulse_restart();
    mem[0] = w_note(20, 4);
    mem[1] = w_note(21, 6);
    ifc.i_enable = 1'b1;
    step();
    ifc.i_enable = 1'b0;
    step();
    ifc.i_restart = 1'b1;
    step();
    ifc.i_restart = 1'b0;
    chk("rsd_valid0", 32'(ifc.o_valid), 0);
    count_valids(6, cnt);
    chk("rsd_nvalid", 32'(cnt), 0);
    chk("rsd_addr", 32'(ifc.o_mem_addr), 0);
    request(10, lat, busy1);
    chk("rsd_lat", 32'(lat), 3);
    chk_entry("rsd", 20, 4, 0, 0);

    // Restart beats a coincident enable
    ifc.i_enable = 1'b1;
    ifc.i_restart = 1'b1;
    step();
    ifc.i_enable = 1'b0;
    ifc.i_restart = 1'b0;
    chk("pri_busy", 32'(ifc.o_busy), 0);
    count_valids(6, cnt);
    chk("pri_nvalid", 32'(cnt), 0);
    chk("pri_addr", 32'(ifc.o_mem_addr), 0);

    // Reset in the DECODE cycle drops the request
    request(10, lat, busy1);
    chk("rd_pre_note", 32'(ifc.o_note), 20);
    ifc.i_enable = 1'b1;
    step();
    ifc.i_enable = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rd_valid0", 32'(ifc.o_valid), 0);
    count_valids(6, cnt);
    chk("rd_nvalid", 32'(cnt), 0);
    chk("rd_addr", 32'(ifc.o_mem_addr), 0);
    request(10, lat, busy1);
    chk("rd_lat", 32'(lat), 3);
    chk_entry("rd", 20, 4, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
